// File: rtl/mpmp_fifo_pkg.sv
// mpmp_fifo_pkg
// Shared types and helpers for the multi-push/multi-pop FIFO push arbiter.
//   arb_state_e : arbiter mode (ARB_NORMAL greedy round-robin, ARB_HOLD owner-only)
//   count_t     : word-count type at the default lane count
//   rr_inc      : modulo-r increment of a requester index
package mpmp_fifo_pkg;

  localparam int PKG_N  = 3;
  localparam int PKG_NW = $clog2(PKG_N + 1);

  typedef enum logic {ARB_NORMAL, ARB_HOLD} arb_state_e;

  typedef logic [PKG_NW-1:0] count_t;

  function automatic int rr_inc(input int idx, input int r);
    return (idx + 1 >= r) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mpmp_push_packer.sv
// mpmp_push_packer
// Purely combinational packer. Requests arrive already rotated so that index 0
// is the round-robin head. Each eligible request that fits entirely in the
// remaining capacity is granted and its words are appended to the lanes.
// Ports:
//   rot_cnt_i   : per-slot word count (rotated order), 0 = idle
//   rot_data_i  : per-slot words, word j at [k][j]
//   can_push_i  : free FIFO slots
//   elig_i      : per-slot eligibility mask (rotated order)
//   rot_gnt_o   : per-slot grant (rotated order)
//   push_o      : total granted words
//   push_data_o : packed lanes, unused lanes are 0
//   last_o      : rotated index of the last granted slot
module mpmp_push_packer
  import mpmp_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 13,
  parameter int N          = 3,
  parameter int R          = 4,
  parameter int NW         = $clog2(N + 1),
  parameter int RW         = $clog2(R)
) (
  input  logic [R-1:0][NW-1:0]                rot_cnt_i,
  input  logic [R-1:0][N-1:0][DATA_WIDTH-1:0] rot_data_i,
  input  logic [NW-1:0]                       can_push_i,
  input  logic [R-1:0]                        elig_i,
  output logic [R-1:0]                        rot_gnt_o,
  output logic [NW-1:0]                       push_o,
  output logic [N-1:0][DATA_WIDTH-1:0]        push_data_o,
  output logic [RW-1:0]                       last_o
);

  int rem;
  int off;
  int cnt;

  always_comb begin
    rot_gnt_o   = '0;
    push_data_o = '0;
    last_o      = '0;
    off         = 0;
    cnt         = 0;
    // Never plan past the lane count even if the FIFO reports more room.
    rem = (int'(can_push_i) > N) ? N : int'(can_push_i);
    for (int k = 0; k < R; k++) begin
      cnt = int'(rot_cnt_i[k]);
      if (elig_i[k] && (cnt != 0) && (cnt <= rem)) begin
        rot_gnt_o[k] = 1'b1;
        for (int l = 0; l < N; l++) begin
          if ((l >= off) && (l < off + cnt)) begin
            push_data_o[l] = rot_data_i[k][l-off];
          end
        end
        off    = off + cnt;
        rem    = rem - cnt;
        last_o = RW'(k);
      end
    end
    push_o = NW'(off);
  end

endmodule

// File: rtl/mpmp_fifo_push_arbiter.sv
// mpmp_fifo_push_arbiter
// Shares the multi-word push port of the MPMP FIFO among R requesters. Whole
// requests are packed into the N lanes in round-robin order without ever
// exceeding can_push_i. Grants are combinational (zero latency).
// Optional macro MPMP_PUSH_ARB_STARVE_GUARD_EN adds per-requester skip counters
// and a HOLD state that reserves the port for a starving requester.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   req_cnt_i    : words each requester wants to push (0 = idle)
//   req_data_i   : requester words, word j at [r][j]
//   gnt_o        : request r consumed this cycle
//   can_push_i   : free slots reported by the FIFO
//   push_o       : word count to FIFO push_i
//   push_data_o  : packed lanes to FIFO push_data_i
//   hold_o       : arbiter is in HOLD state (0 when the guard is compiled out)
module mpmp_fifo_push_arbiter
  import mpmp_fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = 13,
  parameter int N            = 3,
  parameter int R            = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int NW           = $clog2(N + 1),
  parameter int RW           = $clog2(R)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [R-1:0][NW-1:0]                req_cnt_i,
  input  logic [R-1:0][N-1:0][DATA_WIDTH-1:0] req_data_i,
  output logic [R-1:0]                        gnt_o,
  input  logic [NW-1:0]                       can_push_i,
  output logic [NW-1:0]                       push_o,
  output logic [N-1:0][DATA_WIDTH-1:0]        push_data_o,
  output logic                                hold_o
);

  logic [RW-1:0]                        rr_ptr_q, rr_ptr_d;
  logic [R-1:0][NW-1:0]                 rot_cnt;
  logic [R-1:0][N-1:0][DATA_WIDTH-1:0]  rot_data;
  logic [R-1:0]                         elig_rot;
  logic [R-1:0]                         rot_gnt;
  logic [RW-1:0]                        last_rot;
  logic [NW-1:0]                        pk_push;
  logic [N-1:0][DATA_WIDTH-1:0]         pk_data;
  logic [R-1:0]                         gnt;
  logic [RW-1:0]                        last_idx;
  logic                                 any_gnt;

`ifdef MPMP_PUSH_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  arb_state_e            state_q, state_d;
  logic [RW-1:0]         owner_q, owner_d;
  logic [R-1:0][SW-1:0]  skip_cnt_q, skip_cnt_d;
`endif

  // Rotate requests so slot 0 is the round-robin head.
  always_comb begin
    int src;
    rot_cnt  = '0;
    rot_data = '0;
    elig_rot = '0;
    for (int k = 0; k < R; k++) begin
      src         = (int'(rr_ptr_q) + k) % R;
      rot_cnt[k]  = req_cnt_i[src];
      rot_data[k] = req_data_i[src];
`ifdef MPMP_PUSH_ARB_STARVE_GUARD_EN
      elig_rot[k] = (state_q == ARB_NORMAL) || (RW'(src) == owner_q);
`else
      elig_rot[k] = 1'b1;
`endif
    end
  end

  mpmp_push_packer #(
    .DATA_WIDTH (DATA_WIDTH),
    .N          (N),
    .R          (R),
    .NW         (NW),
    .RW         (RW)
  ) u_packer (
    .rot_cnt_i   (rot_cnt),
    .rot_data_i  (rot_data),
    .can_push_i  (can_push_i),
    .elig_i      (elig_rot),
    .rot_gnt_o   (rot_gnt),
    .push_o      (pk_push),
    .push_data_o (pk_data),
    .last_o      (last_rot)
  );

  // Map grants and the last-granted slot back to requester indices.
  always_comb begin
    gnt = '0;
    for (int k = 0; k < R; k++) begin
      gnt[(int'(rr_ptr_q) + k) % R] = rot_gnt[k];
    end
    last_idx = RW'((int'(rr_ptr_q) + int'(last_rot)) % R);
    any_gnt  = |rot_gnt;
  end

  // Outputs are forced quiet while reset is held, even though state has
  // already cleared, so nothing reaches the FIFO during reset.
  assign gnt_o       = rst_i ? '0 : gnt;
  assign push_o      = rst_i ? '0 : pk_push;
  assign push_data_o = rst_i ? '0 : pk_data;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (any_gnt) begin
      rr_ptr_d = RW'(rr_inc(int'(last_idx), R));
    end
`ifdef MPMP_PUSH_ARB_STARVE_GUARD_EN
    begin
      int  src;
      logic found;
      state_d = state_q;
      owner_d = owner_q;
      found   = 1'b0;
      for (int r = 0; r < R; r++) begin
        if ((req_cnt_i[r] == '0) || gnt[r]) begin
          skip_cnt_d[r] = '0;
        end else if (skip_cnt_q[r] != SW'(STARVE_LIMIT)) begin
          skip_cnt_d[r] = skip_cnt_q[r] + SW'(1);
        end else begin
          skip_cnt_d[r] = skip_cnt_q[r];
        end
      end
      if (state_q == ARB_NORMAL) begin
        // First saturated requester in round-robin order becomes owner.
        for (int k = 0; k < R; k++) begin
          src = (int'(rr_ptr_q) + k) % R;
          if (!found && (skip_cnt_d[src] == SW'(STARVE_LIMIT))) begin
            found   = 1'b1;
            state_d = ARB_HOLD;
            owner_d = RW'(src);
          end
        end
      end else if (gnt[owner_q]) begin
        // Owner is the only grant, so rr_ptr_d is already owner + 1.
        state_d = ARB_NORMAL;
      end else if (req_cnt_i[owner_q] == '0) begin
        // Owner withdrew: give it first look next time it returns.
        state_d  = ARB_NORMAL;
        rr_ptr_d = owner_q;
      end
    end
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q   <= '0;
`ifdef MPMP_PUSH_ARB_STARVE_GUARD_EN
      state_q    <= ARB_NORMAL;
      owner_q    <= '0;
      skip_cnt_q <= '0;
`endif
    end else begin
      rr_ptr_q   <= rr_ptr_d;
`ifdef MPMP_PUSH_ARB_STARVE_GUARD_EN
      state_q    <= state_d;
      owner_q    <= owner_d;
      skip_cnt_q <= skip_cnt_d;
`endif
    end
  end

`ifdef MPMP_PUSH_ARB_STARVE_GUARD_EN
  assign hold_o = (state_q == ARB_HOLD);
`else
  assign hold_o = 1'b0;
`endif

endmodule
